// File: rtl/ysyx_23060136_wbu_csr_trap_seq_if.sv
// ysyx_23060136_wbu_csr_trap_seq_if: retire handshake, CSR snapshot inputs, CSR write channels and redirect
interface ysyx_23060136_wbu_csr_trap_seq_if #(
  parameter int BITS_W = 64,
  parameter int CSR_W  = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_op;
  logic [BITS_W-1:0] in_pc;
  logic [CSR_W-1:0]  in_csr_rd;
  logic [BITS_W-1:0] in_csr_wdata;
  logic [BITS_W-1:0] in_cause;
  logic [BITS_W-1:0] in_tval;
  logic [BITS_W-1:0] csr_mstatus;
  logic [BITS_W-1:0] csr_mtvec;
  logic [BITS_W-1:0] csr_mepc;
  logic              CSRWr_1;
  logic              CSRWr_2;
  logic [CSR_W-1:0]  csr_rd_1;
  logic [CSR_W-1:0]  csr_rd_2;
  logic [BITS_W-1:0] csr_busW_1;
  logic [BITS_W-1:0] csr_busW_2;
  logic              redirect_valid;
  logic [BITS_W-1:0] redirect_pc;
  modport master (
    output in_valid, in_op, in_pc, in_csr_rd, in_csr_wdata, in_cause, in_tval,
           csr_mstatus, csr_mtvec, csr_mepc,
    input  in_ready, CSRWr_1, CSRWr_2, csr_rd_1, csr_rd_2, csr_busW_1, csr_busW_2,
           redirect_valid, redirect_pc
  );
  modport slave (
    input  in_valid, in_op, in_pc, in_csr_rd, in_csr_wdata, in_cause, in_tval,
           csr_mstatus, csr_mtvec, csr_mepc,
    output in_ready, CSRWr_1, CSRWr_2, csr_rd_1, csr_rd_2, csr_busW_1, csr_busW_2,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ysyx_23060136_wbu_csr_trap_seq.sv
// ysyx_23060136_wbu_csr_trap_seq: WBU CSR write sequencer for csr writes, two-beat trap entry and mret.
// Define YSYX_23060136_TRAP_MTVAL_EN to also write mtval on the second trap beat.
module ysyx_23060136_wbu_csr_trap_seq #(
  parameter int BITS_W      = 64,
  parameter int CSR_W       = 3,
  parameter int IDX_MSTATUS = 0,
  parameter int IDX_MTVEC   = 1,
  parameter int IDX_MEPC    = 2,
  parameter int IDX_MCAUSE  = 3,
  parameter int IDX_MTVAL   = 6
) (
  input logic clk,
  input logic rst,
  ysyx_23060136_wbu_csr_trap_seq_if.slave b
);
  localparam logic [1:0] IDLE = 2'd0, TRAP1 = 2'd1, TRAP2 = 2'd2;
  localparam logic [CSR_W-1:0] I_MS = CSR_W'(IDX_MSTATUS);
  localparam logic [CSR_W-1:0] I_MT = CSR_W'(IDX_MTVEC);
  localparam logic [CSR_W-1:0] I_EP = CSR_W'(IDX_MEPC);
  localparam logic [CSR_W-1:0] I_MC = CSR_W'(IDX_MCAUSE);
  logic [1:0]        state, n_state;
  logic              rdy, wr1, wr2, rv, n_wr1, n_wr2, n_rv;
  logic [CSR_W-1:0]  rd1, rd2, n_rd1, n_rd2;
  logic [BITS_W-1:0] bw1, bw2, rpc, ms_l, n_bw1, n_bw2, n_rpc, n_ms;
  logic [BITS_W-1:0] ms_b, mt_b, ep_b;
  logic              acc;
  assign acc = b.in_valid & rdy;
  // Writes on the output regs this cycle are not yet in the CSR file; ch1 wins like the file does
  assign ms_b = wr1 && rd1 == I_MS ? bw1 : wr2 && rd2 == I_MS ? bw2 : b.csr_mstatus;
  assign mt_b = wr1 && rd1 == I_MT ? bw1 : wr2 && rd2 == I_MT ? bw2 : b.csr_mtvec;
  assign ep_b = wr1 && rd1 == I_EP ? bw1 : wr2 && rd2 == I_EP ? bw2 : b.csr_mepc;
`ifdef YSYX_23060136_TRAP_MTVAL_EN
  localparam logic [CSR_W-1:0] I_TV = CSR_W'(IDX_MTVAL);
  logic [BITS_W-1:0] tv_l, n_tv;
`else
  logic unused_tval;
  assign unused_tval = ^{b.in_tval, IDX_MTVAL};
`endif
  always_comb begin
    n_state = IDLE;
    n_wr1 = 1'b0;
    n_rd1 = '0;
    n_bw1 = '0;
    n_wr2 = 1'b0;
    n_rd2 = '0;
    n_bw2 = '0;
    n_rv = 1'b0;
    n_rpc = '0;
    n_ms = ms_l;
`ifdef YSYX_23060136_TRAP_MTVAL_EN
    n_tv = tv_l;
`endif
    if (state == TRAP1) begin
      n_state = TRAP2;
      n_wr1 = 1'b1;
      n_rd1 = I_MS;
      n_bw1 = {ms_l[BITS_W-1:13], 2'b11, ms_l[10:8], ms_l[3], ms_l[6:4], 1'b0, ms_l[2:0]};
`ifdef YSYX_23060136_TRAP_MTVAL_EN
      n_wr2 = 1'b1;
      n_rd2 = I_TV;
      n_bw2 = tv_l;
`endif
    end else if (acc) begin
      case (b.in_op)
        2'b01: begin
          n_wr1 = 1'b1;
          n_rd1 = b.in_csr_rd;
          n_bw1 = b.in_csr_wdata;
        end
        2'b10: begin
          n_state = TRAP1;
          n_wr1 = 1'b1;
          n_rd1 = I_EP;
          n_bw1 = b.in_pc;
          n_wr2 = 1'b1;
          n_rd2 = I_MC;
          n_bw2 = b.in_cause;
          n_rv = 1'b1;
          n_rpc = {mt_b[BITS_W-1:2], 2'b00};
          n_ms = ms_b;
`ifdef YSYX_23060136_TRAP_MTVAL_EN
          n_tv = b.in_tval;
`endif
        end
        2'b11: begin
          n_wr1 = 1'b1;
          n_rd1 = I_MS;
          n_bw1 = {ms_b[BITS_W-1:13], 2'b11, ms_b[10:8], 1'b1, ms_b[6:4], ms_b[7], ms_b[2:0]};
          n_rv = 1'b1;
          n_rpc = ep_b;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rdy <= 1'b1;
      wr1 <= 1'b0;
      rd1 <= '0;
      bw1 <= '0;
      wr2 <= 1'b0;
      rd2 <= '0;
      bw2 <= '0;
      rv <= 1'b0;
      rpc <= '0;
      ms_l <= '0;
`ifdef YSYX_23060136_TRAP_MTVAL_EN
      tv_l <= '0;
`endif
    end else begin
      state <= n_state;
      rdy <= n_state != TRAP1;
      wr1 <= n_wr1;
      rd1 <= n_rd1;
      bw1 <= n_bw1;
      wr2 <= n_wr2;
      rd2 <= n_rd2;
      bw2 <= n_bw2;
      rv <= n_rv;
      rpc <= n_rpc;
      ms_l <= n_ms;
`ifdef YSYX_23060136_TRAP_MTVAL_EN
      tv_l <= n_tv;
`endif
    end
  end
  assign b.in_ready = rdy;
  assign b.CSRWr_1 = wr1;
  assign b.csr_rd_1 = rd1;
  assign b.csr_busW_1 = bw1;
  assign b.CSRWr_2 = wr2;
  assign b.csr_rd_2 = rd2;
  assign b.csr_busW_2 = bw2;
  assign b.redirect_valid = rv;
  assign b.redirect_pc = rpc;
endmodule

// File: tb/tb_ysyx_23060136_wbu_csr_trap_seq.sv
// tb_ysyx_23060136_wbu_csr_trap_seq: directed and random retire traffic against a beat-queue CSR model
module tb_ysyx_23060136_wbu_csr_trap_seq;
  typedef struct packed {
    logic        w1;
    logic [2:0]  r1;
    logic [63:0] d1;
    logic        w2;
    logic [2:0]  r2;
    logic [63:0] d2;
    logic        rv;
    logic [63:0] rpc;
  } beat_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tot = 0;
  int pass_n = 0;
  logic [63:0] csr [8];
  beat_t q[$];
  beat_t cur = '0;
  logic exp_rdy = 1'b1;
  ysyx_23060136_wbu_csr_trap_seq_if #(.BITS_W(64), .CSR_W(3)) bus ();
  ysyx_23060136_wbu_csr_trap_seq dut (.clk(clk), .rst(rst), .b(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tot++;
    assert (obs === exp) pass_n++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask
  // Architectural effect of one retiring instruction, expressed as the beats it must produce
  task automatic accept(input logic [1:0] op, input logic [63:0] pc, wd, ca, tv, input logic [2:0] rd);
    beat_t b1 = '0;
    beat_t b2 = '0;
    logic [63:0] ms = csr[0];
    if (op == 2'b01) begin
      b1.w1 = 1; b1.r1 = rd; b1.d1 = wd;
      q.push_back(b1);
    end else if (op == 2'b10) begin
      b1.w1 = 1; b1.r1 = 3'd2; b1.d1 = pc;
      b1.w2 = 1; b1.r2 = 3'd3; b1.d2 = ca;
      b1.rv = 1; b1.rpc = csr[1] & ~64'h3;
      b2.w1 = 1; b2.r1 = 3'd0; b2.d1 = (ms & ~64'h1888) | (ms[3] ? 64'h80 : 64'h0) | 64'h1800;
`ifdef YSYX_23060136_TRAP_MTVAL_EN
      b2.w2 = 1; b2.r2 = 3'd6; b2.d2 = tv;
`endif
      q.push_back(b1);
      q.push_back(b2);
    end else if (op == 2'b11) begin
      b1.w1 = 1; b1.r1 = 3'd0; b1.d1 = (ms & ~64'h1888) | (ms[7] ? 64'h8 : 64'h0) | 64'h1880;
      b1.rv = 1; b1.rpc = csr[2];
      q.push_back(b1);
    end
  endtask
  task automatic step(input logic r, v, input logic [1:0] op, input logic [63:0] pc, wd, ca, tv,
                      input logic [2:0] rd);
    logic acc = v && exp_rdy && !r;
    rst = r;
    bus.in_valid = v; bus.in_op = op; bus.in_pc = pc; bus.in_csr_rd = rd;
    bus.in_csr_wdata = wd; bus.in_cause = ca; bus.in_tval = tv;
    bus.csr_mstatus = csr[0]; bus.csr_mtvec = csr[1]; bus.csr_mepc = csr[2];
    @(posedge clk);
    if (r) begin
      q.delete();
      cur = '0;
      exp_rdy = 1'b1;
    end else begin
      if (cur.w2) csr[cur.r2] = cur.d2;
      if (cur.w1) csr[cur.r1] = cur.d1;
      if (acc) accept(op, pc, wd, ca, tv, rd);
      cur = q.size() != 0 ? q.pop_front() : '0;
      exp_rdy = q.size() == 0;
    end
    #1;
    chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    chk("CSRWr_1", 64'(bus.CSRWr_1), 64'(cur.w1));
    chk("csr_rd_1", 64'(bus.csr_rd_1), 64'(cur.r1));
    chk("csr_busW_1", bus.csr_busW_1, cur.d1);
    chk("CSRWr_2", 64'(bus.CSRWr_2), 64'(cur.w2));
    chk("csr_rd_2", 64'(bus.csr_rd_2), 64'(cur.r2));
    chk("csr_busW_2", bus.csr_busW_2, cur.d2);
    chk("redirect_valid", 64'(bus.redirect_valid), 64'(cur.rv));
    if (cur.rv) chk("redirect_pc", bus.redirect_pc, cur.rpc);
  endtask
  task automatic idle();
    step(1'b0, 1'b0, 2'b00, 64'h0, 64'h0, 64'h0, 64'h0, 3'd0);
  endtask
  initial begin
    for (int i = 0; i < 8; i++) csr[i] = 64'h0;
    step(1'b1, 1'b0, 2'b00, 64'h0, 64'h0, 64'h0, 64'h0, 3'd0);
    step(1'b1, 1'b0, 2'b00, 64'h0, 64'h0, 64'h0, 64'h0, 3'd0);
    chk("rst_ready", 64'(bus.in_ready), 64'h1);
    chk("rst_wr1", 64'(bus.CSRWr_1), 64'h0);
    chk("rst_rpc", bus.redirect_pc, 64'h0);
    step(1'b0, 1'b1, 2'b01, 64'h0, 64'h1234, 64'h0, 64'h0, 3'd4);
    chk("w_wr1", 64'(bus.CSRWr_1), 64'h1);
    chk("w_rd1", 64'(bus.csr_rd_1), 64'd4);
    chk("w_bw1", bus.csr_busW_1, 64'h1234);
    chk("w_wr2", 64'(bus.CSRWr_2), 64'h0);
    idle();
    csr[0] = 64'hA_0000_1808;
    csr[1] = 64'h8000_0101;
    step(1'b0, 1'b1, 2'b10, 64'h8000_0010, 64'h0, 64'd11, 64'hDEAD, 3'd0);
    chk("t1_mepc", bus.csr_busW_1, 64'h8000_0010);
    chk("t1_mcause", bus.csr_busW_2, 64'd11);
    chk("t1_rpc", bus.redirect_pc, 64'h8000_0100);
    chk("t1_ready", 64'(bus.in_ready), 64'h0);
    step(1'b0, 1'b1, 2'b01, 64'h0, 64'h55, 64'h0, 64'h0, 3'd5);
    chk("t2_ms", bus.csr_busW_1, 64'hA_0000_1880);
    chk("t2_rv", 64'(bus.redirect_valid), 64'h0);
    idle();
    csr[0] = 64'h1880;
    csr[2] = 64'h8000_0014;
    step(1'b0, 1'b1, 2'b11, 64'h0, 64'h0, 64'h0, 64'h0, 3'd0);
    chk("mret_ms", bus.csr_busW_1, 64'h1888);
    chk("mret_rpc", bus.redirect_pc, 64'h8000_0014);
    idle();
    csr[0] = 64'h0;
    step(1'b0, 1'b1, 2'b01, 64'h0, 64'h8, 64'h0, 64'h0, 3'd0);
    step(1'b0, 1'b1, 2'b10, 64'h8000_0020, 64'h0, 64'd2, 64'h77, 3'd0);
    idle();
    chk("byp_ms", bus.csr_busW_1, 64'h1880);
    idle();
    step(1'b0, 1'b1, 2'b10, 64'h8000_0030, 64'h0, 64'd5, 64'h99, 3'd0);
    step(1'b1, 1'b0, 2'b00, 64'h0, 64'h0, 64'h0, 64'h0, 3'd0);
    chk("rst_t1_wr1", 64'(bus.CSRWr_1), 64'h0);
    idle();
    chk("rst_t1_idle", 64'(bus.CSRWr_1), 64'h0);
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
           {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
           3'($urandom_range(0, 7)));
    idle();
    idle();
    $display("%0d/%0d checks passed", pass_n, tot);
    $finish;
  end
endmodule
